hex_word_rotator: RTL and testbench

- Sequential control stage placed directly upstream of the 2-bit, 3-to-1 character mux and the 7-segment character decoders.
- Holds a three-character word, where each character is a 2-bit code: 00 = 'd', 01 = 'E', 10 = '1', 11 = blank.
- Auto-rotates the word across HEX2..HEX0 on a prescaled tick, or advances it one position per manual step pulse.
- Outputs the rotation select and the three rotated character codes. These feed the existing decoders and LEDR.

---
 rtl/hex_word_rotator.sv | 96 +++++++++
 tb/tb_hex_word_rotator.sv | 134 +++++++++++++
 2 files changed

// File: rtl/hex_word_rotator.sv
// Three-character word rotator feeding the HEX2..HEX0 character mux and decoders.
// Rotation advances on a prescaled auto tick or on each rising edge of a manual step.
module hex_word_rotator #(
   parameter int CLK_DIV = 50000000,
   parameter int CNT_W   = 26
) (
   input  logic       Clock_i,
   input  logic       Resetn_i,
   input  logic [5:0] Din_i,
   input  logic       Load_i,
   input  logic       En_i,
   input  logic       Dir_i,
   input  logic       Step_i,
   output logic [1:0] Sel_o,
   output logic [1:0] C2_o,
   output logic [1:0] C1_o,
   output logic [1:0] C0_o,
   output logic       Tick_o
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tick_q, tick_d;
   logic             step_q;
   logic [1:0]       sel_q, sel_d;
   logic [1:0]       w0_q, w1_q, w2_q;
   logic             step_edge;
   logic             adv;

   assign step_edge = Step_i & ~step_q;
   assign adv       = step_edge | tick_q;

   always_comb begin
      cnt_d = cnt_q;
      if (Load_i)
         cnt_d = '0;
      else if (En_i)
         cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
   end

   // Tick is registered so it is high exactly while the count sits at CLK_DIV-1.
   assign tick_d = ~Load_i & En_i & (cnt_d == CNT_LAST);

   always_comb begin
      sel_d = sel_q;
      if (Load_i) begin
         sel_d = 2'd0;
      end else if (adv) begin
         case (sel_q)
            2'd0:    sel_d = Dir_i ? 2'd2 : 2'd1;
            2'd1:    sel_d = Dir_i ? 2'd0 : 2'd2;
            2'd2:    sel_d = Dir_i ? 2'd1 : 2'd0;
            default: sel_d = 2'd0;
         endcase
      end
   end

   always_ff @(posedge Clock_i) begin
      if (!Resetn_i) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
         step_q <= 1'b0;
         sel_q  <= 2'd0;
         w0_q   <= 2'b00;
         w1_q   <= 2'b01;
         w2_q   <= 2'b10;
      end else begin
         cnt_q  <= cnt_d;
         tick_q <= tick_d;
         step_q <= Step_i;
         sel_q  <= sel_d;
         if (Load_i) begin
            w0_q <= Din_i[5:4];
            w1_q <= Din_i[3:2];
            w2_q <= Din_i[1:0];
         end
      end
   end

   always_comb begin
      C2_o = 2'b11;
      C1_o = 2'b11;
      C0_o = 2'b11;
      case (sel_q)
         2'd0: begin C2_o = w0_q; C1_o = w1_q; C0_o = w2_q; end
         2'd1: begin C2_o = w1_q; C1_o = w2_q; C0_o = w0_q; end
         2'd2: begin C2_o = w2_q; C1_o = w0_q; C0_o = w1_q; end
         default: ;
      endcase
   end

   assign Sel_o  = sel_q;
   assign Tick_o = tick_q;

endmodule

// File: tb/tb_hex_word_rotator.sv
// Scoreboard bench for hex_word_rotator with CLK_DIV=4: directed rows push the
// hand-computed post-edge outputs, a monitor pops and compares every cycle.
module tb_hex_word_rotator;

   logic       clk = 1'b0;
   logic       rstn, load, en, dir, step;
   logic [5:0] din;
   logic [1:0] sel, c2, c1, c0;
   logic       tick;

   hex_word_rotator #(.CLK_DIV(4), .CNT_W(3)) dut (
      .Clock_i (clk),
      .Resetn_i(rstn),
      .Din_i   (din),
      .Load_i  (load),
      .En_i    (en),
      .Dir_i   (dir),
      .Step_i  (step),
      .Sel_o   (sel),
      .C2_o    (c2),
      .C1_o    (c1),
      .C0_o    (c0),
      .Tick_o  (tick)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         cyc;
      string      name;
      logic [1:0] sel;
      logic [5:0] word;
      logic       tick;
   } exp_t;

   exp_t q[$];
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: compare every expectation whose target cycle has arrived.
   initial begin
      forever begin
         @(posedge clk);
         #3;
         while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if (e.cyc != cyc || sel !== e.sel || {c2, c1, c0} !== e.word || tick !== e.tick) begin
               errors++;
               $display("FAIL %s cyc %0d: got sel=%0d c2c1c0=%b tick=%b, expected sel=%0d c2c1c0=%b tick=%b (target cyc %0d)",
                        e.name, cyc, sel, {c2, c1, c0}, tick, e.sel, e.word, e.tick, e.cyc);
            end else begin
               $display("ok   %s cyc %0d: sel=%0d c2c1c0=%b tick=%b", e.name, cyc, sel, {c2, c1, c0}, tick);
            end
         end
      end
   end

   // Apply one input pattern for n cycles; each cycle expects the given post-edge outputs.
   task automatic v(input string name, input int n, input logic r, input logic ld,
                    input logic e, input logic d, input logic s, input logic [5:0] di,
                    input logic [1:0] xs, input logic [5:0] xw, input logic xt);
      for (int i = 0; i < n; i++) begin
         exp_t x;
         rstn = r; load = ld; en = e; dir = d; step = s; din = di;
         x.cyc = cyc + 1; x.name = name; x.sel = xs; x.word = xw; x.tick = xt;
         q.push_back(x);
         @(posedge clk);
         #1;
      end
   endtask

   // Displayed words: dE1 rotations and the loaded word 11_01_00 rotations.
   localparam logic [5:0] D0 = 6'b000110, D1 = 6'b011000, D2 = 6'b100001;
   localparam logic [5:0] L0 = 6'b110100, L1 = 6'b010011, L2 = 6'b001101;

   initial begin
      rstn = 1'b0; load = 1'b0; en = 1'b0; dir = 1'b0; step = 1'b0; din = 6'b0;
      //     name       n  rst ld en dir st din     sel  word tick
      v("reset",        2, 0, 0, 0, 0, 0, 6'h00, 2'd0, D0, 0);
      v("idle",        20, 1, 0, 0, 0, 0, 6'h00, 2'd0, D0, 0);
      v("fwd",          2, 1, 0, 1, 0, 0, 6'h00, 2'd0, D0, 0);
      v("fwd_tick",     1, 1, 0, 1, 0, 0, 6'h00, 2'd0, D0, 1);
      v("fwd",          3, 1, 0, 1, 0, 0, 6'h00, 2'd1, D1, 0);
      v("fwd_tick",     1, 1, 0, 1, 0, 0, 6'h00, 2'd1, D1, 1);
      v("fwd",          3, 1, 0, 1, 0, 0, 6'h00, 2'd2, D2, 0);
      v("fwd_tick",     1, 1, 0, 1, 0, 0, 6'h00, 2'd2, D2, 1);
      v("fwd",          3, 1, 0, 1, 0, 0, 6'h00, 2'd0, D0, 0);
      v("fwd_tick",     1, 1, 0, 1, 0, 0, 6'h00, 2'd0, D0, 1);
      v("bwd",          3, 1, 0, 1, 1, 0, 6'h00, 2'd2, D2, 0);
      v("bwd_tick",     1, 1, 0, 1, 1, 0, 6'h00, 2'd2, D2, 1);
      v("bwd",          3, 1, 0, 1, 1, 0, 6'h00, 2'd1, D1, 0);
      v("bwd_tick",     1, 1, 0, 1, 1, 0, 6'h00, 2'd1, D1, 1);
      v("bwd",          3, 1, 0, 1, 1, 0, 6'h00, 2'd0, D0, 0);
      v("step_first",   1, 1, 0, 0, 0, 1, 6'h00, 2'd1, D1, 0);
      v("step_hold",    4, 1, 0, 0, 0, 1, 6'h00, 2'd1, D1, 0);
      v("step_low",     2, 1, 0, 0, 0, 0, 6'h00, 2'd1, D1, 0);
      v("step_again",   1, 1, 0, 0, 0, 1, 6'h00, 2'd2, D2, 0);
      v("step_low",     1, 1, 0, 0, 0, 0, 6'h00, 2'd2, D2, 0);
      v("coin_tick",    1, 1, 0, 1, 0, 0, 6'h00, 2'd2, D2, 1);
      v("coin_both",    1, 1, 0, 1, 0, 1, 6'h00, 2'd0, D0, 0);
      v("run",          2, 1, 0, 1, 0, 0, 6'h00, 2'd0, D0, 0);
      v("run_tick",     1, 1, 0, 1, 0, 0, 6'h00, 2'd0, D0, 1);
      v("run",          3, 1, 0, 1, 0, 0, 6'h00, 2'd1, D1, 0);
      v("run_tick",     1, 1, 0, 1, 0, 0, 6'h00, 2'd1, D1, 1);
      v("run",          3, 1, 0, 1, 0, 0, 6'h00, 2'd2, D2, 0);
      v("load",         1, 1, 1, 1, 0, 0, 6'b110100, 2'd0, L0, 0);
      v("post_load",    2, 1, 0, 1, 0, 0, 6'h00, 2'd0, L0, 0);
      v("post_tick",    1, 1, 0, 1, 0, 0, 6'h00, 2'd0, L0, 1);
      v("post_load",    3, 1, 0, 1, 0, 0, 6'h00, 2'd1, L1, 0);
      v("post_tick",    1, 1, 0, 1, 0, 0, 6'h00, 2'd1, L1, 1);
      v("post_load",    1, 1, 0, 1, 0, 0, 6'h00, 2'd2, L2, 0);
      v("mid_reset",    1, 0, 0, 1, 0, 0, 6'h00, 2'd0, D0, 0);
      v("after_rst",    2, 1, 0, 1, 0, 0, 6'h00, 2'd0, D0, 0);
      v("after_tick",   1, 1, 0, 1, 0, 0, 6'h00, 2'd0, D0, 1);
      v("after_rst",    1, 1, 0, 1, 0, 0, 6'h00, 2'd1, D1, 0);
      v("load_hold",    5, 1, 1, 1, 0, 1, 6'b000110, 2'd0, D0, 0);
      en = 1'b0; load = 1'b0; step = 1'b0;
      repeat (3) @(posedge clk);
      #5;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expectations, expected 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
